// File: rtl/ysyx_23060191_lsu_pkg.sv
// Shared definitions for the load/store unit: widths, op codes, FSM states,
// the latched-transaction record, and small op-classification helpers.
// Imported by the LSU top, its alignment sub-module and the memory interface.
package ysyx_23060191_lsu_pkg;

    localparam int CPU_WIDTH     = 32;
    localparam int LSU_OPT_WIDTH = 4;

    localparam logic [3:0] LSU_NONE = 4'd0;
    localparam logic [3:0] LSU_LB   = 4'd1;
    localparam logic [3:0] LSU_LH   = 4'd2;
    localparam logic [3:0] LSU_LW   = 4'd3;
    localparam logic [3:0] LSU_LBU  = 4'd4;
    localparam logic [3:0] LSU_LHU  = 4'd5;
    localparam logic [3:0] LSU_SB   = 4'd6;
    localparam logic [3:0] LSU_SH   = 4'd7;
    localparam logic [3:0] LSU_SW   = 4'd8;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

    // Everything captured from the execute stage at accept time.
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rs2;
    } lsu_txn_t;

    // Unused encodings behave exactly like NONE.
    function automatic logic [3:0] lsu_norm_op(input logic [3:0] op);
        return (op > LSU_SW) ? LSU_NONE : op;
    endfunction

    function automatic logic lsu_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic mis;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: mis = addr_lo[0];
            LSU_LW, LSU_SW:          mis = |addr_lo;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060191_lsu_if.sv
// Memory port between the LSU (master) and the data memory (slave).
// Request: valid/ready with word address, write enable, lane data and strobes.
// Response: single-cycle valid pulse carrying load data or a store ack.
interface ysyx_23060191_lsu_if;
    import ysyx_23060191_lsu_pkg::*;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [CPU_WIDTH-1:0] mem_addr;
    logic                 mem_wen;
    logic [CPU_WIDTH-1:0] mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_rsp_valid;
    logic [CPU_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );

endinterface

// File: rtl/ysyx_23060191_lsu_align.sv
// Purpose: store lane replication/strobes and load byte/half extraction+extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: op_i/addr_lo_i select the access; rs2_i store data; rdata_i memory word;
//        wen_o/wdata_o/wstrb_o store side; load_res_o aligned, extended load value.
module ysyx_23060191_lsu_align
    import ysyx_23060191_lsu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic        wen_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_res_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Halfword loads are already known aligned, so addr_lo[0] only picks a byte.
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign byte_sel = addr_lo_i[0] ? half_sel[15:8] : half_sel[7:0];

    always_comb begin
        wen_o   = 1'b0;
        wdata_o = '0;
        wstrb_o = '0;
        case (op_i)
            LSU_SB: begin
                wen_o   = 1'b1;
                wdata_o = {4{rs2_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            LSU_SH: begin
                wen_o   = 1'b1;
                wdata_o = {2{rs2_i[15:0]}};
                wstrb_o = 4'b0011 << addr_lo_i;
            end
            LSU_SW: begin
                wen_o   = 1'b1;
                wdata_o = rs2_i;
                wstrb_o = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_res_o = '0;
        case (op_i)
            LSU_LB:  load_res_o = {{24{byte_sel[7]}}, byte_sel};
            LSU_LH:  load_res_o = {{16{half_sel[15]}}, half_sel};
            LSU_LW:  load_res_o = rdata_i;
            LSU_LBU: load_res_o = {24'd0, byte_sel};
            LSU_LHU: load_res_o = {16'd0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060191_lsu.sv
// Purpose: single-outstanding load/store stage between execute and writeback.
// Latency: accept->wbu_valid 1 cycle for NONE/misaligned, >=3 cycles for memory ops.
// Backpressure: exu_ready only in IDLE; request held until mem_req_ready; DONE held until wbu_ready.
// Ports: exu_* execute handshake + operands; mem (interface master) memory port;
//        wbu_* writeback handshake; lsu_res/lsu_misalign writeback payload.
module ysyx_23060191_lsu #(
    parameter int CPU_WIDTH     = 32,   // only 32 is supported
    parameter int LSU_OPT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exu_valid,
    output logic                     exu_ready,
    input  logic [CPU_WIDTH-1:0]     exu_res,
    input  logic [CPU_WIDTH-1:0]     data_Rs2,
    input  logic [LSU_OPT_WIDTH-1:0] lsu_opt_code,
    ysyx_23060191_lsu_if.master      mem,
    output logic                     wbu_valid,
    input  logic                     wbu_ready,
    output logic [CPU_WIDTH-1:0]     lsu_res,
    output logic                     lsu_misalign
);
    import ysyx_23060191_lsu_pkg::*;

    logic [1:0]  state_q, state_d;
    lsu_txn_t    txn_q, txn_d;
    logic [31:0] res_q, res_d;
    logic        mis_q, mis_d;

    logic [3:0]  op_in;
    logic        accept;
    logic        in_req;

    logic        al_wen;
    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_load;

    assign op_in     = lsu_norm_op(lsu_opt_code);
    assign exu_ready = (state_q == LSU_IDLE) && !rst;
    assign accept    = exu_valid && exu_ready;
    assign in_req    = (state_q == LSU_REQ);

    ysyx_23060191_lsu_align u_align (
        .op_i       (txn_q.op),
        .addr_lo_i  (txn_q.addr[1:0]),
        .rs2_i      (txn_q.rs2),
        .rdata_i    (mem.mem_rdata),
        .wen_o      (al_wen),
        .wdata_o    (al_wdata),
        .wstrb_o    (al_wstrb),
        .load_res_o (al_load)
    );

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        res_d   = res_q;
        mis_d   = mis_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    txn_d.op   = op_in;
                    txn_d.addr = exu_res;
                    txn_d.rs2  = data_Rs2;
                    if (op_in == LSU_NONE) begin
                        res_d   = exu_res;
                        state_d = LSU_DONE;
                    end else if (lsu_misaligned(op_in, exu_res[1:0])) begin
                        // Report the faulting address; the memory is never touched.
                        res_d   = exu_res;
                        mis_d   = 1'b1;
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (mem.mem_req_ready) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                // Responses are only looked at here, so stray or stale ones elsewhere are dropped.
                if (mem.mem_rsp_valid) begin
                    res_d   = al_wen ? 32'd0 : al_load;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (wbu_ready) begin
                    mis_d   = 1'b0;
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            txn_q   <= '0;
            res_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            res_q   <= res_d;
            mis_q   <= mis_d;
        end
    end

    // Request fields come from latched state, so they stay stable until accepted,
    // and read as zero whenever no request is outstanding.
    assign mem.mem_req_valid = in_req;
    assign mem.mem_addr      = in_req ? {txn_q.addr[31:2], 2'b00} : 32'd0;
    assign mem.mem_wen       = in_req && al_wen;
    assign mem.mem_wdata     = in_req ? al_wdata : 32'd0;
    assign mem.mem_wstrb     = in_req ? al_wstrb : 4'd0;

    assign wbu_valid    = (state_q == LSU_DONE);
    assign lsu_res      = res_q;
    assign lsu_misalign = mis_q;

endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
module tb_ysyx_23060191_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [31:0] exu_res;
    logic [31:0] data_Rs2;
    logic [3:0]  lsu_opt_code;
    logic        wbu_valid;
    logic        wbu_ready;
    logic [31:0] lsu_res;
    logic        lsu_misalign;

    always #5 clk = ~clk;

    ysyx_23060191_lsu_if mem_if();

    ysyx_23060191_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_res      (exu_res),
        .data_Rs2     (data_Rs2),
        .lsu_opt_code (lsu_opt_code),
        .mem          (mem_if),
        .wbu_valid    (wbu_valid),
        .wbu_ready    (wbu_ready),
        .lsu_res      (lsu_res),
        .lsu_misalign (lsu_misalign)
    );

    // Transaction-level expectation for one instruction.
    typedef struct {
        bit          is_mem;
        bit          wen;
        logic [31:0] addr_w;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] res;
        bit          mis;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected observable state for the next falling edge.
    bit   chk_en   = 0;
    bit   exp_rdy  = 0;
    bit   exp_req  = 0;
    bit   exp_wbu  = 0;
    bit   exp_zero = 0;
    exp_t cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Access size/sign from the op, misalignment by divisibility, lanes by arithmetic.
    function automatic exp_t model(input int unsigned op_in, input logic [31:0] a,
                                   input logic [31:0] rs2, input logic [31:0] rd);
        exp_t        e;
        int unsigned op;
        int unsigned size;
        int unsigned off;
        bit          sgn;
        logic [31:0] v;
        e = '{default: 0};
        op = (op_in > 8) ? 0 : op_in;
        size = 0;
        case (op)
            1, 4, 6: size = 1;
            2, 5, 7: size = 2;
            3, 8:    size = 4;
            default: size = 0;
        endcase
        sgn = (op == 1) || (op == 2);
        off = a % 4;
        if (size == 0) begin
            e.res = a;
            return e;
        end
        if ((a % size) != 0) begin
            e.res = a;
            e.mis = 1;
            return e;
        end
        e.is_mem = 1;
        e.addr_w = a - off;
        if (op >= 6) begin
            e.wen   = 1;
            e.wstrb = 4'(((1 << size) - 1) << off);
            if (size == 1)      e.wdata = 32'(rs2 % 256) * 32'h0101_0101;
            else if (size == 2) e.wdata = 32'(rs2 % 65536) * 32'h0001_0001;
            else                e.wdata = rs2;
            e.res = 0;
        end else begin
            v = rd >> (8 * off);
            if (size < 4) begin
                v = v % (32'd1 << (8 * size));
                if (sgn && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
            end
            e.res = v;
        end
        return e;
    endfunction

    // Single compare process: every cycle, outputs against the expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            check("exu_ready", 32'(exu_ready), 32'(exp_rdy));
            check("mem_req_valid", 32'(mem_if.mem_req_valid), 32'(exp_req));
            check("wbu_valid", 32'(wbu_valid), 32'(exp_wbu));
            if (exp_req) begin
                check("mem_addr", mem_if.mem_addr, cur.addr_w);
                check("mem_wen", 32'(mem_if.mem_wen), 32'(cur.wen));
                check("mem_wstrb", 32'(mem_if.mem_wstrb), 32'(cur.wstrb));
                if (cur.wen) check("mem_wdata", mem_if.mem_wdata, cur.wdata);
            end
            if (exp_wbu) begin
                check("lsu_res", lsu_res, cur.res);
                check("lsu_misalign", 32'(lsu_misalign), 32'(cur.mis));
            end
            if (exp_rdy) check("idle_misalign", 32'(lsu_misalign), 32'd0);
            if (exp_zero) begin
                check("zero_addr", mem_if.mem_addr, 32'd0);
                check("zero_wen", 32'(mem_if.mem_wen), 32'd0);
                check("zero_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
                check("zero_wdata", mem_if.mem_wdata, 32'd0);
                check("zero_res", lsu_res, 32'd0);
                check("zero_mis", 32'(lsu_misalign), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_rsp();
        mem_if.mem_rsp_valid = 1'($urandom);
        mem_if.mem_rdata     = $urandom;
    endtask

    task automatic run_txn(input int unsigned op, input logic [31:0] a, input logic [31:0] rs2,
                           input logic [31:0] rd, input int rdy_dly, input int rsp_dly,
                           input int wb_dly);
        exp_t e;
        e = model(op, a, rs2, rd);
        exu_valid    = 1;
        lsu_opt_code = 4'(op);
        exu_res      = a;
        data_Rs2     = rs2;
        step();
        cur      = e;
        exp_rdy  = 0;
        exp_zero = 0;
        // Keep offering junk while busy; none of it may be accepted.
        lsu_opt_code = 4'($urandom);
        exu_res      = $urandom;
        data_Rs2     = $urandom;
        if (e.is_mem) begin
            exp_req = 1;
            mem_if.mem_req_ready = 0;
            repeat (rdy_dly) begin junk_rsp(); step(); end
            junk_rsp();
            mem_if.mem_req_ready = 1;
            step();
            mem_if.mem_req_ready = 0;
            mem_if.mem_rsp_valid = 0;
            exp_req = 0;
            repeat (rsp_dly) step();
            mem_if.mem_rsp_valid = 1;
            mem_if.mem_rdata     = rd;
            step();
            mem_if.mem_rsp_valid = 0;
        end
        exp_wbu   = 1;
        wbu_ready = 0;
        repeat (wb_dly) begin junk_rsp(); step(); end
        junk_rsp();
        wbu_ready = 1;
        step();
        wbu_ready = 0;
        exu_valid = 0;
        mem_if.mem_rsp_valid = 0;
        exp_wbu = 0;
        exp_rdy = 1;
    endtask

    // Reset while waiting for a response, then deliver that response late.
    task automatic reset_mid(input logic [31:0] a, input logic [31:0] rd);
        exu_valid    = 1;
        lsu_opt_code = 4'd3;
        exu_res      = a;
        data_Rs2     = 32'h0;
        step();
        cur      = model(3, a, 0, rd);
        exu_valid = 0;
        exp_rdy  = 0;
        exp_zero = 0;
        exp_req  = 1;
        mem_if.mem_req_ready = 1;
        step();
        mem_if.mem_req_ready = 0;
        exp_req = 0;
        step();
        rst = 1;
        step();
        exp_zero = 1;
        rst = 0;
        exp_rdy = 1;
        mem_if.mem_rsp_valid = 1;
        mem_if.mem_rdata     = rd;
        step();
        step();
        mem_if.mem_rsp_valid = 0;
        step();
    endtask

    initial begin
        exp_t e;
        rst = 1;
        exu_valid = 0; exu_res = 0; data_Rs2 = 0; lsu_opt_code = 0; wbu_ready = 0;
        mem_if.mem_req_ready = 0; mem_if.mem_rsp_valid = 0; mem_if.mem_rdata = 0;

        // Hand-computed values that pin the model.
        e = model(0, 32'h1234_5678, 0, 0);
        check("pin_none_res", e.res, 32'h1234_5678);
        check("pin_none_mem", 32'(e.is_mem), 32'd0);
        e = model(6, 32'h8000_0003, 32'h0000_00A5, 0);
        check("pin_sb_addr", e.addr_w, 32'h8000_0000);
        check("pin_sb_strb", 32'(e.wstrb), 32'h8);
        check("pin_sb_wdata", e.wdata, 32'hA5A5_A5A5);
        e = model(4, 32'h8000_0002, 0, 32'h1280_FF00);
        check("pin_lbu", e.res, 32'h0000_0080);
        e = model(1, 32'h8000_0002, 0, 32'h1280_FF00);
        check("pin_lb", e.res, 32'hFFFF_FF80);
        e = model(3, 32'h8000_0006, 0, 0);
        check("pin_lw_mis", 32'(e.mis), 32'd1);
        check("pin_lw_mis_res", e.res, 32'h8000_0006);
        e = model(2, 32'h8000_0002, 0, 32'h8001_0000);
        check("pin_lh", e.res, 32'hFFFF_8001);
        e = model(7, 32'h8000_0002, 32'h1234_ABCD, 0);
        check("pin_sh_wdata", e.wdata, 32'hABCD_ABCD);
        check("pin_sh_strb", 32'(e.wstrb), 32'hC);

        step();
        step();
        chk_en   = 1;
        exp_zero = 1;
        exp_rdy  = 0;
        step();
        rst = 0;
        exp_rdy = 1;
        step();

        // Directed cases.
        run_txn(0, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 0);
        run_txn(6, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0);
        run_txn(4, 32'h8000_0002, 32'h0, 32'h1280_FF00, 0, 0, 0);
        run_txn(1, 32'h8000_0002, 32'h0, 32'h1280_FF00, 0, 0, 0);
        run_txn(3, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0);
        run_txn(2, 32'h8000_0002, 32'h0, 32'h8001_0000, 3, 2, 0);
        run_txn(12, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 1);
        run_txn(8, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1, 1, 4);
        reset_mid(32'h8000_0020, 32'h5555_AAAA);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            repeat ($urandom_range(0, 2)) step();
            run_txn($urandom_range(0, 15), a, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        step();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_lsu.md
Name: ysyx_23060191_lsu

Overview:
Load/store stage directly downstream of the execute unit. It consumes the execute result as the effective address (or as a pass-through result), issues one aligned word request on a simple valid/ready memory port, and aligns and extends load data. It presents the final writeback value to the writeback stage over a valid/ready handshake. It is single-outstanding: one instruction at a time.

Parameters:
CPU_WIDTH, 32, datapath/address width; only 32 is supported.
LSU_OPT_WIDTH, 4, width of the lsu_opt_code field.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exu_valid  in  1  execute result valid
exu_ready  out  1  LSU can accept; high only in IDLE and not in reset
exu_res  in  32  effective address, or pass-through result for non-memory ops
data_Rs2  in  32  store data
lsu_opt_code  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 are treated as NONE
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wen  out  1  request is a store
mem_wdata  out  32  store data replicated into lanes
mem_wstrb  out  4  byte strobes; 0 for loads
mem_rsp_valid  in  1  response (load data or store ack) valid
mem_rdata  in  32  load word
wbu_valid  out  1  result valid to writeback
wbu_ready  in  1  writeback accepts
lsu_res  out  32  writeback value
lsu_misalign  out  1  access was misaligned; no memory access was made

Behaviour:
- Reset: on rst=1 at a clk edge, the state goes to IDLE. All outputs reset to 0: exu_ready, mem_req_valid, mem_wen, mem_wstrb, mem_addr, mem_wdata, wbu_valid, lsu_res, lsu_misalign. exu_ready is forced to 0 while rst=1.
- States: IDLE, REQ, WAIT_RSP, DONE. The state and all latched fields are registered.
- IDLE:
  - exu_ready=1.
  - On exu_valid&exu_ready, latch op, addr, and data_Rs2.
  - NONE: lsu_res<=exu_res, go to DONE. One-cycle latency.
  - Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): lsu_res<=addr, lsu_misalign<=1, go to DONE. No memory request is made.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1, with mem_addr, mem_wen, mem_wdata, and mem_wstrb stable until accepted.
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=rs2, wstrb=4'b1111.
  - On mem_req_ready, go to WAIT_RSP. mem_req_valid drops the next cycle.
- WAIT_RSP:
  - Wait for mem_rsp_valid. A response is never accepted in the same cycle as the request handshake.
  - Loads: select the byte/half by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word. Result goes to lsu_res.
  - Stores: lsu_res<=0.
  - Go to DONE.
- DONE:
  - wbu_valid=1; lsu_res and lsu_misalign are held stable.
  - On wbu_ready, go to IDLE and clear lsu_misalign. Under backpressure, hold indefinitely.
- Minimum latencies, accept to wbu_valid: NONE/misaligned 1 cycle; memory op 3 cycles when ready and response arrive immediately.
- Boundary conditions:
  - mem_rsp_valid outside WAIT_RSP is ignored, including a stale response after a mid-operation reset.
  - Reset in REQ or WAIT_RSP abandons the access; no retry.
  - exu_valid while not in IDLE is not accepted, because exu_ready=0.

Decomposition:
- Shared defines file:
  - LSU_OPT_WIDTH and the LSU_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW macros.
  - State encodings LSU_IDLE/REQ/WAIT/DONE.
  - Reuse CPU_WIDTH.
- One natural sub-module: ysyx_23060191_lsu_align. It is combinational: store lane replication and strobes, and load extraction and extension by op/addr[1:0]. The FSM lives in the top module.

Test Plan:
- NONE, exu_res=0x1234_5678 -> wbu_valid the next cycle, lsu_res=0x1234_5678, no mem_req_valid.
- SB at addr 0x8000_0003, rs2=0x0000_00A5 -> mem_addr=0x8000_0000, wstrb=4'b1000, wdata=0xA5A5_A5A5, wen=1; after ack, lsu_res=0.
- LB at 0x8000_0002, mem_rdata=0x1280_FF00 -> lsu_res=0x0000_0080 after LBU, 0xFFFF_FF80 after LB.
- LW at 0x8000_0006 -> lsu_misalign=1, lsu_res=0x8000_0006, no memory request, 1-cycle latency.
- LH at 0x8000_0002 with mem_req_ready held low 3 cycles, rsp 2 cycles later, rdata=0x8001_0000 -> request fields stable throughout; lsu_res=0xFFFF_8001.
- Hold wbu_ready=0 for 4 cycles in DONE, then assert rst in WAIT_RSP of the next op and inject a late mem_rsp_valid -> outputs hold under backpressure; after reset state is IDLE, the response is ignored, and wbu_valid stays 0.
